// File: rtl/bist_controller.sv
// BIST engine: LFSR pattern generator, 49-bit MISR compactor, and a run/compare FSM that
// reports bistdone/bistpass. Define BIST_SIG_PORT_EN to expose the MISR on a `signature` port.
`timescale 1ns/1ps

module bist_controller #(
    parameter int unsigned NUM_PATTERNS = 2000,
    parameter logic [34:0] LFSR_SEED    = 35'h1,
    parameter logic [48:0] GOLDEN_SIG   = 49'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bistmode,
    input  logic [34:0] pi,
    input  logic [48:0] cut_po,
    output logic [34:0] cut_pi,
    output logic        bistdone,
    output logic        bistpass
`ifdef BIST_SIG_PORT_EN
    ,
    output logic [48:0] signature
`endif
);

    localparam int unsigned    CW       = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [34:0]   lfsr_q, lfsr_d;
    logic [48:0]   misr_q, misr_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic [34:0]   lfsr_next;
    logic [48:0]   misr_next;

    // x^35+x^2+1 Fibonacci LFSR and x^49+x^9+1 MISR.
    assign lfsr_next = {lfsr_q[33:0], lfsr_q[34] ^ lfsr_q[1]};
    assign misr_next = {misr_q[47:0], misr_q[48] ^ misr_q[8]} ^ cut_po;

    always_comb begin
        // NOTE: every target gets a hold/default value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;

        unique case (state_q)
            S_IDLE: begin
                lfsr_d  = LFSR_SEED;
                misr_d  = '0;
                count_d = '0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                if (bistmode) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_next;
                misr_d = misr_next;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CW'(1);
                end
                if (count_q == LAST_CNT) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving BIST mode aborts from any active state and restores the IDLE values.
        if (!bistmode && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            lfsr_d  = LFSR_SEED;
            misr_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign cut_pi   = bistmode ? lfsr_q : pi;
    assign bistdone = done_q;
    assign bistpass = pass_q;
`ifdef BIST_SIG_PORT_EN
    assign signature = misr_q;
`endif

    a_pass_needs_done : assert property (@(posedge clk) disable iff (rst)
        pass_q |-> done_q);

    a_done_holds : assert property (@(posedge clk) disable iff (rst)
        (state_q == S_DONE && bistmode) |=> (done_q && $stable(pass_q) && $stable(misr_q)));

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test engine inside `chip`, sitting between the chip pins and the s5378-style CUT instance `circuit`. In system mode it passes the 35-bit primary inputs straight to the CUT. In BIST mode it drives the CUT from an LFSR pattern generator and compacts the 49-bit CUT response in a MISR. It then compares the final signature against a golden value and reports the result on `bistdone`/`bistpass` to the pins.

## Interface
- `NUM_PATTERNS`, 2000: patterns applied per BIST run; must be ≥1.
- `LFSR_SEED`, 35'h1: LFSR value loaded on reset and on every return to IDLE; must be non-zero.
- `GOLDEN_SIG`, 49'h0: expected fault-free MISR signature, taken from a fault-free run.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `bistmode  in  1`: 1 selects BIST, 0 selects system mode.
- `pi  in  35`: chip primary inputs.
- `cut_po  in  49`: CUT primary outputs.
- `cut_pi  out  35`: CUT primary inputs.
- `bistdone  out  1`: BIST run complete.
- `bistpass  out  1`: signature matched; valid only while `bistdone`=1.

## Operation
- `cut_pi` = `bistmode` ? `lfsr` : `pi`. This mux is combinational.
- LFSR is Fibonacci x^35+x^2+1: next = {lfsr[33:0], lfsr[34]^lfsr[1]}. From seed 1 the sequence is 1, 2, 5, 10, …
- MISR is 49-bit, x^49+x^9+1:
  - next[0] = misr[48]^misr[8]^cut_po[0]
  - next[i] = misr[i-1]^cut_po[i] for i = 1..48
- Pattern counter: width $clog2(NUM_PATTERNS+1), unsigned, no wrap.
- FSM states:
  - **IDLE**: lfsr=LFSR_SEED, misr=0, count=0, done=0, pass=0. If `bistmode`=1, go to RUN.
  - **RUN**: each cycle, LFSR advances, MISR captures `cut_po`, count increments. When count==NUM_PATTERNS-1 on a clock edge, go to COMPARE.
  - **COMPARE**: on the next edge register pass = (misr==GOLDEN_SIG), set done=1, go to DONE.
  - **DONE**: hold done, pass, misr and lfsr frozen.
- Abort: `bistmode` falling to 0 in RUN, COMPARE or DONE returns to IDLE on the next edge, clearing all state.
- `rst` asserted in any state forces IDLE immediately (asynchronously), with all registers at their IDLE values.
- `bistmode` rising while `rst` is high has no effect until `rst` falls.

## Timing
- Reset values: `bistdone`=0, `bistpass`=0. `cut_pi` follows the combinational mux (LFSR_SEED if `bistmode`=1, else `pi`).
- With `bistmode`=1 held, count clock edges from the first edge after `rst` falls:
  - edge 1: IDLE→RUN
  - edges 2…NUM_PATTERNS+1: one pattern captured each
  - edge NUM_PATTERNS+2: `bistdone` rises
- Total latency is NUM_PATTERNS+2 cycles.
- `bistdone` and `bistpass` are registered outputs and change only on clock edges or asynchronous reset.
- `bistpass` and `bistdone` update on the same edge; `bistpass` never glitches while `bistdone`=1.
- `bistdone` stays high until `rst` or `bistmode`=0.

## Configuration
- `BIST_SIG_PORT_EN`:
  - Defined: adds output port `signature[48:0]`, which continuously equals the MISR register (0 in reset/IDLE). Used for golden-signature extraction.
  - Undefined: the port does not exist; behaviour is otherwise identical.

## Test plan
- **Reset values:** `rst`=1, `bistmode`=0, `pi`=35'h5A5A5A5A5 → `bistdone`=0, `bistpass`=0, `cut_pi`=35'h5A5A5A5A5 throughout.
- **LFSR sequence:** release `rst` with `bistmode`=1, seed 1 → `cut_pi` = 1 in IDLE, then 1, 2, 5, 10 on successive RUN cycles.
- **Pass case:** NUM_PATTERNS=1, stub CUT `cut_po`={14'b0,`cut_pi`}, GOLDEN_SIG=49'h1 → `bistdone`=1 exactly 3 edges after `rst` falls, `bistpass`=1; signature=49'h1 when BIST_SIG_PORT_EN is defined.
- **Fail case:** same setup with `cut_po[0]` forced to 0 → `bistdone`=1 at edge 3, `bistpass`=0.
- **Abort:** NUM_PATTERNS=2000, drop `bistmode` at edge 500 → IDLE next edge, `bistdone`=0. Re-raising `bistmode` gives a full new run with `bistdone` at 2002 edges and the same signature as an uninterrupted run.
- **Async reset mid-run:** assert `rst` between edges during RUN → `bistdone`=0 and `cut_pi`=LFSR_SEED immediately, before the next edge.
